// File: rtl/imem_loader_pkg.sv
// Shared definitions for the IMEM program loader: widths and the loader state type.
// The CHECK state exists only when IMEM_LOADER_CHECKSUM_EN is defined.
package imem_loader_pkg;

   localparam int unsigned WORD_W  = 16;
   localparam int unsigned IMEM_AW = 16;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_LEN_HI,
      ST_LEN_LO,
      ST_DATA_HI,
      ST_DATA_LO,
      ST_WRITE,
`ifdef IMEM_LOADER_CHECKSUM_EN
      ST_CHECK,
`endif
      ST_DONE,
      ST_ERR
   } ld_state_e;

endpackage

// File: rtl/imem_loader_word_asm.sv
// Captures the HI/LO payload bytes into one big-endian 16-bit word.
// With IMEM_LOADER_CHECKSUM_EN it also keeps a running XOR of every payload byte.
module loader_word_asm
   import imem_loader_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              clear,
   input  logic              hi_en,
   input  logic              lo_en,
   input  logic [7:0]        byte_in,
   output logic [WORD_W-1:0] word
`ifdef IMEM_LOADER_CHECKSUM_EN
   ,
   output logic [7:0]        xor_sum
`endif
);

   logic [7:0]        hi_q, hi_d;
   logic [WORD_W-1:0] word_q, word_d;

   always_comb begin
      hi_d   = hi_q;
      word_d = word_q;
      if (hi_en) hi_d = byte_in;
      if (lo_en) word_d = {hi_q, byte_in};
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         hi_q   <= '0;
         word_q <= '0;
      end else begin
         hi_q   <= hi_d;
         word_q <= word_d;
      end
   end

   assign word = word_q;

`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [7:0] xor_q, xor_d;

   always_comb begin
      xor_d = xor_q;
      if (clear)               xor_d = '0;
      else if (hi_en || lo_en) xor_d = xor_q ^ byte_in;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) xor_q <= '0;
      else        xor_q <= xor_d;
   end

   assign xor_sum = xor_q;
`endif

endmodule

// File: rtl/imem_loader.sv
// Streams a length-prefixed big-endian byte image into IMEM at ascending word addresses,
// holding the CPU until done. Optional trailing XOR check: IMEM_LOADER_CHECKSUM_EN.
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = IMEM_AW,
   parameter int unsigned MAX_WORDS  = 256
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [7:0]            byte_in,
   input  logic                  byte_valid,
   output logic                  byte_ready,
   output logic                  imem_we,
   output logic [ADDR_WIDTH-1:0] imem_waddr,
   output logic [WORD_W-1:0]     imem_wdata,
   output logic                  cpu_hold,
   output logic                  busy,
   output logic                  done,
   output logic                  error
);

`ifdef IMEM_LOADER_CHECKSUM_EN
   localparam ld_state_e ST_FINAL = ST_CHECK;
   logic [7:0] xor_sum;
`else
   localparam ld_state_e ST_FINAL = ST_DONE;
`endif

   ld_state_e             state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [15:0]           remain_q, remain_d;
   logic [7:0]            len_hi_q, len_hi_d;
   logic [15:0]           len_word;
   logic                  accept, hi_en, lo_en, clear_sum;

   assign byte_ready = (state_q == ST_LEN_HI)  || (state_q == ST_LEN_LO) ||
                       (state_q == ST_DATA_HI) || (state_q == ST_DATA_LO)
`ifdef IMEM_LOADER_CHECKSUM_EN
                       || (state_q == ST_CHECK)
`endif
                       ;
   assign accept   = byte_valid && byte_ready;
   assign len_word = {len_hi_q, byte_in};

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      remain_d  = remain_q;
      len_hi_d  = len_hi_q;
      hi_en     = 1'b0;
      lo_en     = 1'b0;
      clear_sum = 1'b0;
      unique case (state_q)
         ST_IDLE, ST_DONE, ST_ERR: begin
            if (start) begin
               state_d   = ST_LEN_HI;
               addr_d    = '0;
               clear_sum = 1'b1;
            end
         end
         ST_LEN_HI: begin
            if (accept) begin
               len_hi_d = byte_in;
               state_d  = ST_LEN_LO;
            end
         end
         ST_LEN_LO: begin
            if (accept) begin
               remain_d = len_word;
               if (32'(len_word) > MAX_WORDS) state_d = ST_ERR;
               else if (len_word == 16'd0)    state_d = ST_FINAL;
               else                           state_d = ST_DATA_HI;
            end
         end
         ST_DATA_HI: begin
            if (accept) begin
               hi_en   = 1'b1;
               state_d = ST_DATA_LO;
            end
         end
         ST_DATA_LO: begin
            if (accept) begin
               lo_en   = 1'b1;
               state_d = ST_WRITE;
            end
         end
         ST_WRITE: begin
            addr_d   = addr_q + ADDR_WIDTH'(1);
            remain_d = remain_q - 16'd1;
            state_d  = (remain_q == 16'd1) ? ST_FINAL : ST_DATA_HI;
         end
`ifdef IMEM_LOADER_CHECKSUM_EN
         ST_CHECK: begin
            if (accept) state_d = (byte_in == xor_sum) ? ST_DONE : ST_ERR;
         end
`endif
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= ST_IDLE;
         addr_q   <= '0;
         remain_q <= '0;
         len_hi_q <= '0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         remain_q <= remain_d;
         len_hi_q <= len_hi_d;
      end
   end

   loader_word_asm u_word_asm (
      .clk     (clk),
      .reset   (reset),
      .clear   (clear_sum),
      .hi_en   (hi_en),
      .lo_en   (lo_en),
      .byte_in (byte_in),
      .word    (imem_wdata)
`ifdef IMEM_LOADER_CHECKSUM_EN
      ,
      .xor_sum (xor_sum)
`endif
   );

   // ERR keeps the CPU held so a rejected image never runs.
   assign imem_we    = (state_q == ST_WRITE);
   assign imem_waddr = addr_q;
   assign done       = (state_q == ST_DONE);
   assign error      = (state_q == ST_ERR);
   assign cpu_hold   = (state_q != ST_IDLE) && (state_q != ST_DONE);
   assign busy       = (state_q != ST_IDLE) && (state_q != ST_DONE) && (state_q != ST_ERR);

endmodule

// File: tb/tb_imem_loader.sv
// Randomized self-checking bench for imem_loader against a byte-stream image model.
// Checksum cases are exercised when IMEM_LOADER_CHECKSUM_EN is defined.
`timescale 1ns/1ps
module tb_imem_loader;

   localparam int unsigned MAXW = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        start = 1'b0;
   logic [7:0]  byte_in = '0;
   logic        byte_valid = 1'b0;
   logic        byte_ready, imem_we, cpu_hold, busy, done, error;
   logic [15:0] imem_waddr, imem_wdata;

   imem_loader #(.ADDR_WIDTH(16), .MAX_WORDS(MAXW)) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .byte_in    (byte_in),
      .byte_valid (byte_valid),
      .byte_ready (byte_ready),
      .imem_we    (imem_we),
      .imem_waddr (imem_waddr),
      .imem_wdata (imem_wdata),
      .cpu_hold   (cpu_hold),
      .busy       (busy),
      .done       (done),
      .error      (error)
   );

   always #5 clk = ~clk;

   int unsigned n_vec = 0;
   int unsigned n_err = 0;
   int unsigned gap_mode = 0;
   logic [15:0] img[$];
   logic [15:0] got_addr[$];
   logic [15:0] got_data[$];

   always @(negedge clk) begin
      if (imem_we) begin
         got_addr.push_back(imem_waddr);
         got_data.push_back(imem_wdata);
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Entered and left at a negedge; garbage on byte_in while idle must be ignored.
   task automatic send_byte(input logic [7:0] b);
      int unsigned gaps;
      int unsigned waited;
      gaps = (gap_mode == 1) ? 1 : (gap_mode == 2) ? $urandom_range(0, 3) : 0;
      for (int unsigned i = 0; i < gaps; i++) begin
         byte_valid = 1'b0;
         byte_in    = 8'($urandom);
         @(negedge clk);
      end
      byte_valid = 1'b1;
      byte_in    = b;
      waited     = 0;
      while (!byte_ready && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      check("byte_ready_wait", byte_ready, 1);
      if (byte_ready) begin
         @(posedge clk);
         @(negedge clk);
      end
      byte_valid = 1'b0;
      byte_in    = 8'($urandom);
   endtask

   task automatic do_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("armed_flags", {busy, cpu_hold, done, error, byte_ready}, 5'b11001);
   endtask

   task automatic run_load(input logic [15:0] len, input logic [7:0] ck_flip, input bit poke_start);
      logic [7:0]  x;
      bit          exp_err;
      int unsigned nexp;
      x = '0;
      got_addr.delete();
      got_data.delete();
      exp_err = (32'(len) > MAXW);
      nexp    = exp_err ? 0 : int'(len);
      do_start();
      send_byte(len[15:8]);
      if (poke_start) begin
         start = 1'b1;
         @(negedge clk);
         start = 1'b0;
      end
      send_byte(len[7:0]);
      if (!exp_err) begin
         for (int unsigned i = 0; i < nexp; i++) begin
            send_byte(img[i][15:8]);
            send_byte(img[i][7:0]);
            x = x ^ img[i][15:8] ^ img[i][7:0];
         end
`ifdef IMEM_LOADER_CHECKSUM_EN
         send_byte(x ^ ck_flip);
         exp_err = (ck_flip != 8'h00);
`endif
      end
      for (int k = 0; k < 2 && !(done || error); k++) @(negedge clk);
      check("done", done, !exp_err);
      check("error", error, exp_err);
      check("cpu_hold", cpu_hold, exp_err);
      check("busy_rdy", {busy, byte_ready}, 2'b00);
      check("write_count", got_addr.size(), nexp);
      for (int unsigned i = 0; i < nexp && i < got_addr.size(); i++) begin
         check("waddr", got_addr[i], i);
         check("wdata", got_data[i], img[i]);
      end
   endtask

   task automatic rand_image(input int unsigned n);
      img.delete();
      for (int unsigned i = 0; i < n; i++) img.push_back(16'($urandom));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] len;
      logic [7:0]  flip;
      reset = 1'b1;
      #1 reset = 1'b0;
      #2;
      check("rst_flags", {byte_ready, imem_we, cpu_hold, busy, done, error}, 6'b0);
      check("rst_waddr", imem_waddr, 0);
      check("rst_wdata", imem_wdata, 0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);

      img = '{16'h1234, 16'hABCD};
      run_load(16'd2, 8'h00, 1'b0);
      img.delete();
      run_load(16'd0, 8'h00, 1'b0);
      run_load(16'd5, 8'h00, 1'b0);
      run_load(16'h0100, 8'h00, 1'b0);
      rand_image(MAXW);
      run_load(16'(MAXW), 8'h00, 1'b0);

      gap_mode = 1;
      img = '{16'h1234, 16'hABCD};
      run_load(16'd2, 8'h00, 1'b1);

`ifdef IMEM_LOADER_CHECKSUM_EN
      gap_mode = 0;
      img = '{16'h1234};
      run_load(16'd1, 8'h00, 1'b0);
      run_load(16'd1, 8'h01, 1'b0);
`endif

      gap_mode = 0;
      img = '{16'h1234, 16'hABCD};
      got_addr.delete();
      got_data.delete();
      do_start();
      send_byte(8'h00);
      send_byte(8'h02);
      send_byte(8'h12);
      send_byte(8'h34);
      check("we_before_reset", {imem_we, imem_wdata}, {1'b1, 16'h1234});
      #2 reset = 1'b0;
      #1;
      check("midrst_flags", {byte_ready, imem_we, cpu_hold, busy, done, error}, 6'b0);
      check("midrst_waddr", imem_waddr, 0);
      check("midrst_wdata", imem_wdata, 0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      run_load(16'd2, 8'h00, 1'b0);

      gap_mode = 2;
      for (int t = 0; t < 40; t++) begin
         case ($urandom_range(0, 9))
            0:       len = 16'($urandom_range(MAXW + 1, 65535));
            1:       len = 16'h0100 + 16'($urandom_range(0, MAXW));
            default: len = 16'($urandom_range(0, MAXW));
         endcase
         flip = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
         rand_image(MAXW);
         run_load(len, flip, 1'($urandom_range(0, 1)));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
